// File: rtl/rpu_msg_pkg.sv
// Shared message types for the decoder datapath: sign-magnitude and
// two's-complement check-node messages at the default width.
package rpu_msg_pkg;

  localparam int RPU_MSG_W = 6;

  typedef struct packed {
    logic                 sign;
    logic [RPU_MSG_W-2:0] mag;
  } sm_msg_t;

  typedef logic [RPU_MSG_W-1:0] tc_msg_t;

endpackage

// File: rtl/sm_to_tc_stream_pipe_stage.sv
// One valid/ready register slice. The payload loads only on an accepted valid
// beat, so held data stays stable under backpressure.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sm_to_tc_stream.sv
// Two-stage sign-magnitude to two's-complement message converter with
// backpressure. Define SM2TC_OFFSET_EN to apply offset min-sum correction in S1.
module sm_to_tc_stream
  import rpu_msg_pkg::*;
#(
  parameter int w      = RPU_MSG_W,
  parameter int OFFSET = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sign,
  input  logic [w-2:0] in_mag,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [w-1:0] out_data,
  output logic         out_last,
  input  logic         clr_flag,
  output logic         negz_flag
);

  logic         s1_adv, s2_adv;
  logic         s1_valid, s2_valid;
  logic [w-2:0] eff_mag;
  logic [w:0]   s1_in, s1_out;
  logic [w:0]   s2_in, s2_out;
  logic         s1_sign, s1_last;
  logic [w-2:0] s1_mag;
  logic [w-1:0] tc_data;
  logic         negz_q, negz_d;

`ifdef SM2TC_OFFSET_EN
  localparam logic [w-2:0] OFF_C = (w-1)'(OFFSET);
  // Saturate at zero rather than wrap when the offset exceeds the magnitude.
  assign eff_mag = (in_mag > OFF_C) ? in_mag - OFF_C : '0;
`else
  assign eff_mag = in_mag;
`endif

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign s1_in = {in_sign, in_last, eff_mag};

  pipe_stage #(.W(w+1)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (s1_adv),
    .valid_i (in_valid),
    .data_i  (s1_in),
    .valid_o (s1_valid),
    .data_o  (s1_out)
  );

  assign {s1_sign, s1_last, s1_mag} = s1_out;

  // Negative zero folds to +0, so -2^(w-1) can never be formed.
  assign tc_data = (s1_sign && (s1_mag != '0)) ? (~{1'b0, s1_mag}) + 1'b1
                                               : {1'b0, s1_mag};
  assign s2_in   = {s1_last, tc_data};

  pipe_stage #(.W(w+1)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (s2_adv),
    .valid_i (s1_valid),
    .data_i  (s2_in),
    .valid_o (s2_valid),
    .data_o  (s2_out)
  );

  assign out_valid            = s2_valid;
  assign {out_last, out_data} = s2_out;

  always_comb begin
    negz_d = negz_q;
    if (in_valid && in_ready && in_sign && (eff_mag == '0)) negz_d = 1'b1;
    else if (clr_flag)                                      negz_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) negz_q <= 1'b0;
    else     negz_q <= negz_d;
  end

  assign negz_flag = negz_q;

endmodule
